// File: rtl/demux1_4_stream.sv
// demux1_4_stream
// Registered 1-to-4 stream demultiplexer. Each input word is steered to the
// lane named by in_sel and lands in that lane's one-entry holding register.
// Every lane keeps a count of the words it has accepted.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both 1 in the cycle before that edge. A source holds valid and its payload
// stable until that transfer. Ready may depend combinationally on the
// source's payload (in_sel) but never on valid.
module demux1_4_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [1:0]              in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [4*DATA_WIDTH-1:0] out_data,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready,
    input  logic                    cnt_clr,
    input  logic [1:0]              cnt_rd_sel,
    output logic [CNT_WIDTH-1:0]    cnt_rd_val
);

    logic [DATA_WIDTH-1:0] lane_data [4];
    logic [CNT_WIDTH-1:0]  lane_cnt  [4];
    logic [3:0]            lane_full;
    logic [3:0]            lane_load;
    logic [3:0]            lane_drain;
    logic                  accept;

    // The selected lane can take a word if it is empty or is draining this cycle.
    assign in_ready   = ~lane_full[in_sel] | out_ready[in_sel];
    assign accept     = in_valid & in_ready;
    assign lane_drain = lane_full & out_ready;
    assign out_valid  = lane_full;
    assign cnt_rd_val = lane_cnt[cnt_rd_sel];

    // One-hot load strobe: only the addressed lane sees an accepted word.
    always_comb begin
        lane_load = 4'b0000;
        if (accept) begin
            lane_load[in_sel] = 1'b1;
        end
    end

    // Pack the lane holding registers onto the flat output bus.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < 4; k++) begin
            out_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_data[k];
        end
    end

    // Per-lane full flag and data: a load wins over a drain in the same cycle,
    // and data is left untouched after a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_full <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                lane_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (lane_load[k]) begin
                    lane_full[k] <= 1'b1;
                    lane_data[k] <= in_data;
                end else if (lane_drain[k]) begin
                    lane_full[k] <= 1'b0;
                end
            end
        end
    end

    // Accepted-word counters; clear takes priority but still counts a
    // same-cycle accept so that word is not lost from the tally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                lane_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (cnt_clr) begin
                    lane_cnt[k] <= lane_load[k] ? CNT_WIDTH'(1) : '0;
                end else if (lane_load[k]) begin
                    lane_cnt[k] <= lane_cnt[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_demux1_4_stream.sv
// tb_demux1_4_stream
// Self-checking bench: directed scenarios followed by randomized traffic,
// all compared each cycle against a lane-level reference model and a
// per-lane expected-word queue.
module tb_demux1_4_stream;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [4*DW-1:0] out_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic          cnt_clr;
    logic [1:0]    cnt_rd_sel;
    logic [CW-1:0] cnt_rd_val;

    int checks;
    int errors;

    // reference model: which lanes hold a word, their words, their counts
    bit      m_full [4];
    int      m_data [4];
    int      m_cnt  [4];
    logic [DW-1:0] exp_q [4][$];

    demux1_4_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .cnt_rd_sel(cnt_rd_sel), .cnt_rd_val(cnt_rd_val)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 0;
            m_data[k] = 0;
            m_cnt[k]  = 0;
            exp_q[k].delete();
        end
    endtask

    // Drive one cycle of inputs, compare DUT against the model, then advance the model.
    task automatic step(input logic r, input logic iv, input logic [1:0] sel,
                        input logic [DW-1:0] d, input logic [3:0] ordy,
                        input logic clr, input logic [1:0] rdsel);
        bit acc;
        logic [3:0]    e_valid;
        logic [4*DW-1:0] e_data;
        @(negedge clk);
        rst = r; in_valid = iv; in_sel = sel; in_data = d;
        out_ready = ordy; cnt_clr = clr; cnt_rd_sel = rdsel;
        #1;
        acc = iv && (!m_full[sel] || ordy[sel]);
        for (int k = 0; k < 4; k++) begin
            e_valid[k] = m_full[k];
            e_data[k*DW +: DW] = DW'(m_data[k]);
        end
        check_val("in_ready", 64'(in_ready), 64'(!m_full[sel] || ordy[sel]));
        check_val("out_valid", 64'(out_valid), 64'(e_valid));
        check_val("out_data", 64'(out_data), 64'(e_data));
        check_val("cnt_rd_val", 64'(cnt_rd_val), 64'(m_cnt[rdsel]));
        if (r) begin
            model_reset();
        end else begin
            // scoreboard: every drained word must be the next one routed to that lane
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && ordy[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check_val("drain_unexpected", 64'(k), 64'hFF);
                    end else begin
                        check_val("drain_word", 64'(out_data[k*DW +: DW]), 64'(exp_q[k].pop_front()));
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (m_full[k] && ordy[k]) m_full[k] = 0;
                if (clr) m_cnt[k] = 0;
            end
            if (acc) begin
                m_full[sel] = 1;
                m_data[sel] = int'(d);
                m_cnt[sel]  = (m_cnt[sel] + 1) % (1 << CW);
                exp_q[sel].push_back(d);
            end
        end
    endtask

    // Let the edge following the last step happen, then sample.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0;
        out_ready = 4'b0000; cnt_clr = 1'b0; cnt_rd_sel = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);

        // route: single word to lane 2, lane not ready
        step(0, 1, 2'd2, 8'hA5, 4'b0000, 0, 2'd2);
        settle();
        check_val("route_valid", 64'(out_valid), 64'h4);
        check_val("route_data", 64'(out_data[2*DW +: DW]), 64'hA5);
        step(0, 1, 2'd2, 8'h01, 4'b0000, 0, 2'd2);
        step(0, 1, 2'd0, 8'h02, 4'b0000, 0, 2'd0);

        // backpressure on lane 1, then simultaneous drain and load
        step(1, 0, 2'd0, 8'h00, 4'b0000, 0, 2'd0);
        step(0, 1, 2'd1, 8'h5A, 4'b0000, 0, 2'd1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 2'd1, DW'($urandom_range(0, 255)), 4'b0000, 0, 2'd1);
        end
        step(0, 1, 2'd1, 8'h77, 4'b0010, 0, 2'd1);
        settle();
        check_val("bp_valid", 64'(out_valid[1]), 64'h1);
        check_val("bp_data", 64'(out_data[1*DW +: DW]), 64'h77);

        // independence: lane 0 stalled, lanes 1..3 accept back to back
        step(1, 0, 2'd0, 8'h00, 4'b0000, 0, 2'd0);
        step(0, 1, 2'd0, 8'hEE, 4'b0000, 0, 2'd0);
        step(0, 1, 2'd1, 8'h11, 4'b0000, 0, 2'd1);
        step(0, 1, 2'd2, 8'h22, 4'b0000, 0, 2'd2);
        step(0, 1, 2'd3, 8'h33, 4'b0000, 0, 2'd3);
        settle();
        check_val("indep_valid", 64'(out_valid), 64'hF);
        check_val("indep_data", 64'(out_data), 64'h332211EE);

        // throughput: eight consecutive words on lane 3
        step(1, 0, 2'd0, 8'h00, 4'b0000, 0, 2'd3);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2'd3, DW'(8'h40 + i), 4'b1000, 0, 2'd3);
        end
        settle();
        check_val("thru_cnt", 64'(cnt_rd_val), 64'd8);
        check_val("thru_last", 64'(out_data[3*DW +: DW]), 64'h47);

        // counter wrap after 256 accepts, then clear with accept
        step(1, 0, 2'd0, 8'h00, 4'b0000, 0, 2'd0);
        for (int i = 0; i < 256; i++) begin
            step(0, 1, 2'd0, DW'(i), 4'b0001, 0, 2'd0);
        end
        settle();
        check_val("wrap_cnt", 64'(cnt_rd_val), 64'd0);
        step(0, 1, 2'd0, 8'h9C, 4'b0001, 1, 2'd0);
        settle();
        check_val("clr_acc_cnt", 64'(cnt_rd_val), 64'd1);

        // reset with every lane full
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 2'(k), DW'(8'hC0 + k), 4'b0000, 0, 2'(k));
        end
        step(1, 0, 2'd0, 8'h00, 4'b0000, 0, 2'd0);
        settle();
        check_val("rst_valid", 64'(out_valid), 64'h0);
        check_val("rst_data", 64'(out_data), 64'h0);
        check_val("rst_cnt0", 64'(cnt_rd_val), 64'h0);

        // randomized traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), DW'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 31) == 0),
                 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
